gyruss_sound_cmd: RTL and testbench
===================================

GYRUSS_SOUND_CMD -- requirements
Module: gyruss_sound_cmd

Interface
REQ-001 Parameter DEPTH_LOG2, default 2: command FIFO depth = 2**DEPTH_LOG2 entries.
REQ-002 Parameter HOLDOFF, default 15: minimum MCLK cycles SIRQ stays low after an acknowledge.
REQ-003 MCLK  in  1  single clock; all state on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SNDRQ  in  1  main-side sound request, a level held for several MCLK cycles per command.
REQ-006 SNDNO  in  8  main-side command byte, stable while SNDRQ is high.
REQ-007 SRD  in  1  sound-CPU latch-read strobe, one MCLK per read; pops the FIFO.
REQ-008 SIACK  in  1  sound-CPU interrupt-acknowledge strobe, one MCLK wide.
REQ-009 SCMD  out  8  command byte presented to the sound CPU.
REQ-010 SIRQ  out  1  interrupt request to the sound CPU, registered.
REQ-011 SPEND  out  1  high while the FIFO holds at least one command.
REQ-012 SCNT  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-013 SOVR  out  1  sticky overflow flag.

Function
REQ-014 Request detect: register sreq_d <= SNDRQ each cycle; push event = SNDRQ & ~sreq_d (one push per SNDRQ high period).
REQ-015 Push: at the edge where the push event is sampled, write SNDNO at wr_ptr, advance wr_ptr modulo depth, increment count.
REQ-016 Pop: SRD with count != 0 advances rd_ptr modulo depth, decrements count, and loads the popped byte into the last-value register.
REQ-017 SRD with count == 0 has no effect on pointers, count, or SCMD.
REQ-018 SCMD is the combinational FIFO head (mem[rd_ptr]) while count != 0; otherwise it is the last-value register, mirroring a plain latch.
REQ-019 Push when full and no pop in the same cycle: drop the byte, leave pointers and count unchanged, and set SOVR.
REQ-020 Push and pop in the same cycle: both take effect and count is unchanged. When full, this is not an overflow. When empty, only the push takes effect.
REQ-021 SOVR clears only on reset.
REQ-022 SPEND = (count != 0); SCNT = count; both are combinational from registers.
REQ-023 IRQ state machine, 3 states:
- IDLE: SIRQ low. Go to ASSERT on the edge where count != 0.
- ASSERT: SIRQ high. On SIACK, go to HOLD and load the hold counter with HOLDOFF.
- HOLD: SIRQ low. Decrement the hold counter each cycle and go to IDLE when it reaches 0.
REQ-024 SIACK outside ASSERT is ignored.
REQ-025 SIRQ is a registered decode of the state. Latency from the push edge to SIRQ high is exactly 1 MCLK cycle (push at edge k, SIRQ high after edge k+1).
REQ-026 If commands remain after HOLD, the IDLE-to-ASSERT transition re-raises SIRQ. The minimum low time is HOLDOFF+1 cycles.
REQ-027 The hold counter is wide enough for HOLDOFF; HOLDOFF=0 gives exactly 1 cycle in HOLD.

Reset
REQ-028 On RESET_N low, immediately and asynchronously:
- pointers, count, last-value register: 0
- SCMD: 0x00; SIRQ, SPEND, SOVR: 0; SCNT: 0
- state: IDLE; hold counter: 0
REQ-029 sreq_d resets to 1, so SNDRQ held high across reset release does not push.
REQ-030 Reset mid-operation discards queued commands and any pending IRQ without further output activity.
REQ-031 FIFO memory contents need not be cleared.

Verification
REQ-032 Single command: SNDNO=0x5A, SNDRQ high 64 cycles -> exactly one push; SCNT=1, SPEND=1 and SCMD=0x5A after the push edge; SIRQ high one cycle later.
REQ-033 Ack/holdoff (HOLDOFF=15): push 0x11 and 0x22, pulse SIACK -> SIRQ low 16 cycles, then high again. SRD twice -> SCMD 0x11 then 0x22, then holds 0x22 with SPEND=0.
REQ-034 Overflow (depth 4): push 0x01..0x05 without SRD -> SCNT=4, SOVR=1. Reads return 0x01..0x04, and 0x05 is lost.
REQ-035 Simultaneous push and pop at full -> SCNT stays 4 and SOVR stays 0. Simultaneous push and pop when empty -> SCNT=1 and SCMD = pushed byte.
REQ-036 Async reset with 3 queued commands and SIRQ high -> all outputs 0 immediately. SNDRQ held high through reset release -> no push.
REQ-037 Spurious strobes: SRD while empty and SIACK while IDLE -> no change to SCNT, SCMD, SIRQ, or state.

Source files
------------

// File: rtl/gyruss_sound_cmd_if.sv
// Sound-command bus between the main CPU side, the command FIFO and the sound CPU.
// The master drives the requests and strobes. The slave (the command block) returns the
// command byte and its status.
interface gyruss_sound_cmd_if #(
    parameter int DEPTH_LOG2 = 2
);
    logic                  SNDRQ;
    logic [7:0]            SNDNO;
    logic                  SRD;
    logic                  SIACK;
    logic [7:0]            SCMD;
    logic                  SIRQ;
    logic                  SPEND;
    logic [DEPTH_LOG2:0]   SCNT;
    logic                  SOVR;

    modport master (
        output SNDRQ, SNDNO, SRD, SIACK,
        input  SCMD, SIRQ, SPEND, SCNT, SOVR
    );

    modport slave (
        input  SNDRQ, SNDNO, SRD, SIACK,
        output SCMD, SIRQ, SPEND, SCNT, SOVR
    );
endinterface

// File: rtl/gyruss_sound_cmd.sv
// Gyruss sound-command path.
// Main-side requests are edge-detected and queued in a small FIFO. The sound CPU is
// interrupted while commands are pending. Each interrupt acknowledge is followed by a
// hold-off period during which SIRQ stays low.
module gyruss_sound_cmd #(
    parameter int DEPTH_LOG2 = 2,
    parameter int HOLDOFF    = 15
) (
    input  logic               MCLK,
    input  logic               RESET_N,
    gyruss_sound_cmd_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_FULL  = CW'(DEPTH);
    localparam logic [HW-1:0]         HOLD_INIT = HW'(HOLDOFF);
    localparam logic [HW-1:0]         HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [7:0]            r_last;
    logic                  r_sreq_d;
    logic                  r_ovr;
    state_t                r_state;
    logic [HW-1:0]         r_hold_cnt;
    logic                  r_sirq;

    logic                  w_push_ev;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    state_t                w_state_next;
    logic [HW-1:0]         w_hold_next;

    // A rising SNDRQ level is one command. A push into a full FIFO is only accepted
    // when a pop frees a slot on the same edge. Otherwise the byte is dropped.
    assign w_push_ev = bus.SNDRQ & ~r_sreq_d;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_pop     = bus.SRD & ~w_empty;
    assign w_push    = w_push_ev & (~w_full | w_pop);
    assign w_drop    = w_push_ev & w_full & ~w_pop;

    // The FIFO storage is never reset. An empty FIFO never exposes its contents.
    always_ff @(posedge MCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.SNDNO;
        end
    end

    // Request edge detector, pointers, occupancy, last-read byte and sticky overflow.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sreq_d <= 1'b1;   // a request already high at reset release is not a command
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
            r_ovr    <= 1'b0;
        end else begin
            r_sreq_d <= bus.SNDRQ;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    // IRQ state register. SIRQ is registered from the next state, so it is high in
    // exactly the cycles that follow an edge into ASSERT.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_sirq     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_next;
            r_sirq     <= (w_state_next == ST_ASSERT);
        end
    end

    // IRQ next-state logic. HOLD counts down from HOLDOFF. HOLD is left on the edge
    // where the count reaches zero, and a count that starts at zero still costs one
    // HOLD cycle.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_next = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (bus.SIACK) begin
                    w_state_next = ST_HOLD;
                    w_hold_next  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt <= HOLD_ONE) begin
                    w_state_next = ST_IDLE;
                    w_hold_next  = '0;
                end else begin
                    w_hold_next  = r_hold_cnt - HOLD_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_hold_next  = '0;
            end
        endcase
    end

    // The FIFO head is visible while commands are pending. When the FIFO is empty,
    // the last byte read is held, as a plain latch would hold it.
    assign bus.SCMD  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign bus.SIRQ  = r_sirq;
    assign bus.SPEND = ~w_empty;
    assign bus.SCNT  = r_count;
    assign bus.SOVR  = r_ovr;

endmodule

// File: tb/tb_gyruss_sound_cmd.sv
// Self-checking bench for gyruss_sound_cmd: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_gyruss_sound_cmd;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
    localparam int HOLDOFF    = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    gyruss_sound_cmd_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus();

    gyruss_sound_cmd #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .HOLDOFF    (HOLDOFF)
    ) dut (
        .MCLK    (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.SNDRQ = 1'b0;
        bus.SNDNO = 8'h00;
        bus.SRD   = 1'b0;
        bus.SIACK = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One command: SNDRQ is high for three cycles, then low for one.
    task automatic push_byte(input logic [7:0] b);
        bus.SNDNO = b;
        bus.SNDRQ = 1'b1;
        step();
        step();
        step();
        bus.SNDRQ = 1'b0;
        step();
    endtask

    task automatic pop_byte();
        bus.SRD = 1'b1;
        step();
        bus.SRD = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.SNDRQ = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.SCMD !== 8'h00 || bus.SIRQ !== 1'b0 || bus.SPEND !== 1'b0 ||
            bus.SCNT !== 3'd0 || bus.SOVR !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got scmd=%h sirq=%b spend=%b scnt=%0d sovr=%b, expected all 0",
                     bus.SCMD, bus.SIRQ, bus.SPEND, bus.SCNT, bus.SOVR);
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (5) step();
        n_tests++;
        if (bus.SCNT !== 3'd0 || bus.SIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_no_push: got scnt=%0d sirq=%b, expected 0 0", bus.SCNT, bus.SIRQ);
        end
        bus.SNDRQ = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.SNDNO = 8'h5A;
        bus.SNDRQ = 1'b1;
        step();
        n_tests++;
        if (bus.SCNT !== 3'd1 || bus.SPEND !== 1'b1 || bus.SCMD !== 8'h5A || bus.SIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push_edge: got scnt=%0d spend=%b scmd=%h sirq=%b, expected 1 1 5a 0",
                     bus.SCNT, bus.SPEND, bus.SCMD, bus.SIRQ);
        end
        step();
        n_tests++;
        if (bus.SIRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL single_irq_latency: got sirq=%b, expected 1", bus.SIRQ);
        end
        repeat (62) step();
        bus.SNDRQ = 1'b0;
        step();
        n_tests++;
        if (bus.SCNT !== 3'd1 || bus.SCMD !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_one_push: got scnt=%0d scmd=%h, expected 1 5a", bus.SCNT, bus.SCMD);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_ack_holdoff();
        int low;
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        n_tests++;
        if (bus.SIRQ !== 1'b1 || bus.SCNT !== 3'd2) begin
            n_fail++;
            $display("FAIL ack_pre: got sirq=%b scnt=%0d, expected 1 2", bus.SIRQ, bus.SCNT);
        end
        bus.SIACK = 1'b1;
        step();
        bus.SIACK = 1'b0;
        low = 0;
        while (bus.SIRQ === 1'b0 && low < 40) begin
            low++;
            step();
        end
        n_tests++;
        if (low != HOLDOFF + 1) begin
            n_fail++;
            $display("FAIL ack_low_time: got %0d low cycles, expected %0d", low, HOLDOFF + 1);
        end
        n_tests++;
        if (bus.SCMD !== 8'h11) begin
            n_fail++;
            $display("FAIL ack_head0: got scmd=%h, expected 11", bus.SCMD);
        end
        pop_byte();
        step();
        n_tests++;
        if (bus.SCMD !== 8'h22 || bus.SCNT !== 3'd1) begin
            n_fail++;
            $display("FAIL ack_head1: got scmd=%h scnt=%0d, expected 22 1", bus.SCMD, bus.SCNT);
        end
        pop_byte();
        repeat (3) step();
        n_tests++;
        if (bus.SCMD !== 8'h22 || bus.SPEND !== 1'b0 || bus.SCNT !== 3'd0) begin
            n_fail++;
            $display("FAIL ack_hold_last: got scmd=%h spend=%b scnt=%0d, expected 22 0 0",
                     bus.SCMD, bus.SPEND, bus.SCNT);
        end
        $display("[TB] test_ack_holdoff done");
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            push_byte(b);
        end
        n_tests++;
        if (bus.SCNT !== 3'd4 || bus.SOVR !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: got scnt=%0d sovr=%b, expected 4 0", bus.SCNT, bus.SOVR);
        end
        push_byte(8'h05);
        n_tests++;
        if (bus.SCNT !== 3'd4 || bus.SOVR !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got scnt=%0d sovr=%b, expected 4 1", bus.SCNT, bus.SOVR);
        end
        for (int i = 1; i <= 4; i++) begin
            b = 8'(i);
            n_tests++;
            if (bus.SCMD !== b) begin
                n_fail++;
                $display("FAIL ovf_read%0d: got scmd=%h, expected %h", i, bus.SCMD, b);
            end
            pop_byte();
        end
        n_tests++;
        if (bus.SCNT !== 3'd0 || bus.SCMD !== 8'h04 || bus.SOVR !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drained: got scnt=%0d scmd=%h sovr=%b, expected 0 04 1",
                     bus.SCNT, bus.SCMD, bus.SOVR);
        end
        $display("[TB] test_overflow done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        do_reset();
        exp_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (exp_q[i]) push_byte(exp_q[i]);
        bus.SNDNO = 8'hE5;
        bus.SNDRQ = 1'b1;
        bus.SRD   = 1'b1;
        step();
        bus.SRD   = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(8'hE5);
        n_tests++;
        if (bus.SCNT !== 3'd4 || bus.SOVR !== 1'b0 || bus.SCMD !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_full: got scnt=%0d sovr=%b scmd=%h, expected 4 0 %h",
                     bus.SCNT, bus.SOVR, bus.SCMD, exp_q[0]);
        end
        bus.SNDRQ = 1'b0;
        step();
        while (exp_q.size() > 0) begin
            n_tests++;
            if (bus.SCMD !== exp_q[0]) begin
                n_fail++;
                $display("FAIL b2b_drain: got scmd=%h, expected %h", bus.SCMD, exp_q[0]);
            end
            void'(exp_q.pop_front());
            pop_byte();
        end
        do_reset();
        bus.SNDNO = 8'h3C;
        bus.SNDRQ = 1'b1;
        bus.SRD   = 1'b1;
        step();
        bus.SRD   = 1'b0;
        bus.SNDRQ = 1'b0;
        n_tests++;
        if (bus.SCNT !== 3'd1 || bus.SCMD !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_empty: got scnt=%0d scmd=%h, expected 1 3c", bus.SCNT, bus.SCMD);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        bus.SNDNO = 8'h33;
        bus.SNDRQ = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.SCNT !== 3'd3 || bus.SIRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre: got scnt=%0d sirq=%b, expected 3 1", bus.SCNT, bus.SIRQ);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.SCMD !== 8'h00 || bus.SIRQ !== 1'b0 || bus.SPEND !== 1'b0 ||
            bus.SCNT !== 3'd0 || bus.SOVR !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: got scmd=%h sirq=%b spend=%b scnt=%0d sovr=%b, expected all 0",
                     bus.SCMD, bus.SIRQ, bus.SPEND, bus.SCNT, bus.SOVR);
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        n_tests++;
        if (bus.SCNT !== 3'd0 || bus.SIRQ !== 1'b0 || bus.SPEND !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: got scnt=%0d sirq=%b spend=%b, expected 0 0 0",
                     bus.SCNT, bus.SIRQ, bus.SPEND);
        end
        bus.SNDRQ = 1'b0;
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_spurious();
        do_reset();
        bus.SRD = 1'b1;
        step();
        bus.SRD = 1'b0;
        n_tests++;
        if (bus.SCNT !== 3'd0 || bus.SCMD !== 8'h00 || bus.SIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_srd: got scnt=%0d scmd=%h sirq=%b, expected 0 00 0",
                     bus.SCNT, bus.SCMD, bus.SIRQ);
        end
        bus.SIACK = 1'b1;
        step();
        bus.SIACK = 1'b0;
        step();
        n_tests++;
        if (bus.SCNT !== 3'd0 || bus.SCMD !== 8'h00 || bus.SIRQ !== 1'b0) begin
            n_fail++;
            $display("FAIL spur_siack: got scnt=%0d scmd=%h sirq=%b, expected 0 00 0",
                     bus.SCNT, bus.SCMD, bus.SIRQ);
        end
        // If the stray acknowledge had moved the IRQ logic out of IDLE, this push
        // would not raise SIRQ one cycle later.
        bus.SNDNO = 8'h77;
        bus.SNDRQ = 1'b1;
        step();
        step();
        bus.SNDRQ = 1'b0;
        n_tests++;
        if (bus.SIRQ !== 1'b1 || bus.SCMD !== 8'h77) begin
            n_fail++;
            $display("FAIL spur_then_push: got sirq=%b scmd=%h, expected 1 77", bus.SIRQ, bus.SCMD);
        end
        $display("[TB] test_spurious done");
    endtask

    // Random SNDRQ levels, SNDNO bytes and SRD strobes, with no SIACK. The reference
    // model is a byte queue with a capacity of DEPTH. Once the queue has held a command
    // before some edge, SIRQ stays high after that edge.
    task automatic test_random();
        logic [7:0] q[$];
        logic       m_prev;
        logic       m_ovr;
        logic [7:0] m_last;
        logic       m_irq;
        logic       push;
        logic       pop;
        int         cnt_before;
        logic [7:0] exp_cmd;
        do_reset();
        q.delete();
        m_prev = 1'b0;
        m_ovr  = 1'b0;
        m_last = 8'h00;
        m_irq  = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.SNDRQ = ~bus.SNDRQ;
            end
            if (!bus.SNDRQ) begin
                bus.SNDNO = 8'($urandom);
            end
            bus.SRD = ($urandom_range(0, 3) == 0);
            cnt_before = q.size();
            push   = bus.SNDRQ && !m_prev;
            m_prev = bus.SNDRQ;
            pop    = bus.SRD && (q.size() != 0);
            if (pop) begin
                m_last = q.pop_front();
            end
            if (push) begin
                if (q.size() < DEPTH) q.push_back(bus.SNDNO);
                else m_ovr = 1'b1;
            end
            m_irq = m_irq || (cnt_before != 0);
            step();
            exp_cmd = (q.size() != 0) ? q[0] : m_last;
            n_tests++;
            if (bus.SCNT !== 3'(q.size()) || bus.SPEND !== (q.size() != 0)) begin
                n_fail++;
                $display("FAIL rand_count cyc%0d: got scnt=%0d spend=%b, expected %0d %b",
                         cyc, bus.SCNT, bus.SPEND, q.size(), (q.size() != 0));
            end
            n_tests++;
            if (bus.SCMD !== exp_cmd) begin
                n_fail++;
                $display("FAIL rand_scmd cyc%0d: got %h, expected %h", cyc, bus.SCMD, exp_cmd);
            end
            n_tests++;
            if (bus.SOVR !== m_ovr || bus.SIRQ !== m_irq) begin
                n_fail++;
                $display("FAIL rand_flags cyc%0d: got sovr=%b sirq=%b, expected %b %b",
                         cyc, bus.SOVR, bus.SIRQ, m_ovr, m_irq);
            end
        end
        idle_inputs();
        $display("[TB] test_random done");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_ack_holdoff();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a scenario stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
